// File: rtl/clk_lock_pkg.sv
// Shared definitions for the PLL lock monitor: FSM states, frequency constants
// and the measurement window acceptance test.
package clk_lock_pkg;

    localparam int unsigned REF_CLK_HZ = 12_000_000;
    localparam int unsigned SYS_CLK_HZ = 50_000_000;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } lock_state_t;

    // Unsigned window acceptance; lower bound clamps at zero for wide tolerances
    function automatic logic in_range(input int unsigned m,
                                      input int unsigned exp_edges,
                                      input int unsigned tolerance);
        int unsigned lo;
        lo = (tolerance > exp_edges) ? 32'd0 : exp_edges - tolerance;
        return (m >= lo) && (m <= exp_edges + tolerance);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/clk_lock_monitor.sv
// Counts reference-clock edges per gate window and declares PLL lock after
// a run of in-tolerance windows; holds downstream logic in reset until locked.
module clk_lock_monitor
    import clk_lock_pkg::*;
#(
    parameter  int unsigned GATE_CYCLES  = 50000,
    parameter  int unsigned EXPECT_EDGES = 12000,
    parameter  int unsigned TOLERANCE    = 12,
    parameter  int unsigned LOCK_COUNT   = 4,
    localparam int unsigned CW           = $clog2(GATE_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ref_in,
    output logic          locked,
    output logic          rst_out,
    output logic [CW-1:0] edge_count,
    output logic          meas_valid,
    output logic          lock_lost
);

    localparam int unsigned GW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned GOODW = $clog2(LOCK_COUNT + 1);

    logic              edge_now_c;
    logic [GW-1:0]     gate;
    logic [CW-1:0]     acc;
    logic [CW-1:0]     meas_c;
    logic              gate_end_c;
    logic              meas_ok_c;
    logic [GOODW-1:0]  good;
    lock_state_t       state;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ref_in),
        .rise_c   (edge_now_c)
    );

    // Saturating running total including this cycle's edge
    assign gate_end_c = (gate == GW'(GATE_CYCLES - 1));
    assign meas_c     = (&acc) ? acc : acc + CW'(edge_now_c);
    assign meas_ok_c  = in_range(32'(meas_c), EXPECT_EDGES, TOLERANCE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate       <= '0;
            acc        <= '0;
            edge_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= gate_end_c;
            if (gate_end_c) begin
                gate       <= '0;
                acc        <= '0;
                edge_count <= meas_c;
            end else begin
                gate <= gate + GW'(1);
                acc  <= meas_c;
            end
        end
    end

    // Lock decision is taken as the window closes so locked moves with meas_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACQUIRE;
            good      <= '0;
            locked    <= 1'b0;
            rst_out   <= 1'b1;
            lock_lost <= 1'b0;
        end else begin
            rst_out <= ~locked;
            if (gate_end_c) begin
                case (state)
                    ACQUIRE: begin
                        if (meas_ok_c) begin
                            if ((32'(good) + 32'd1) >= LOCK_COUNT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                good   <= '0;
                            end else begin
                                good <= good + GOODW'(1);
                            end
                        end else begin
                            good <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!meas_ok_c) begin
                            state     <= ACQUIRE;
                            locked    <= 1'b0;
                            lock_lost <= 1'b1;
                            good      <= '0;
                            rst_out   <= 1'b1;
                        end
                    end
                    default: state <= ACQUIRE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_lock_monitor.sv
// Directed-plus-random bench for clk_lock_monitor with a queue-based edge model.
module tb_clk_lock_monitor;

    localparam int GATE = 100;
    localparam int EXP  = 12;
    localparam int TOL  = 1;
    localparam int LCNT = 4;
    localparam int CW   = $clog2(GATE + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ref_in = 1'b0;
    logic          locked;
    logic          rst_out;
    logic [CW-1:0] edge_count;
    logic          meas_valid;
    logic          lock_lost;

    int checks = 0;
    int errors = 0;

    int ref_period  = 8;
    int ref_phase   = 0;
    bit ref_on      = 1'b1;
    bit ref_manual  = 1'b0;
    bit ref_man_val = 1'b0;

    int   mon_n = 0;
    logic mon_prev = 1'b0;
    int   edge_q[$];

    bit m_locked = 1'b0;
    bit m_lost   = 1'b0;
    int m_run    = 0;
    int win      = 0;

    clk_lock_monitor #(
        .GATE_CYCLES  (GATE),
        .EXPECT_EDGES (EXP),
        .TOLERANCE    (TOL),
        .LOCK_COUNT   (LCNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ref_in     (ref_in),
        .locked     (locked),
        .rst_out    (rst_out),
        .edge_count (edge_count),
        .meas_valid (meas_valid),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    // Reference source, updated on falling clk edges
    initial begin
        ref_phase = int'($urandom_range(0, 7));
        forever begin
            @(negedge clk);
            if (ref_manual) begin
                ref_in = ref_man_val;
            end else if (ref_on) begin
                ref_phase = (ref_phase + 1) % ref_period;
                ref_in    = (ref_phase < ref_period / 2);
            end else begin
                ref_in = 1'b0;
            end
        end
    end

    // Record the clk-cycle index of every sampled rising edge since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mon_n    <= 0;
            mon_prev <= 1'b0;
            edge_q.delete();
        end else begin
            if (ref_in && !mon_prev) edge_q.push_back(mon_n);
            mon_prev <= ref_in;
            mon_n    <= mon_n + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // An edge sampled at cycle n is accumulated two cycles later
    function automatic int exp_count(input int w);
        int c = 0;
        foreach (edge_q[i]) if ((edge_q[i] + 2) / GATE == w) c++;
        return c;
    endfunction

    function automatic void reset_model();
        m_locked = 1'b0;
        m_lost   = 1'b0;
        m_run    = 0;
        win      = 0;
    endfunction

    task automatic check_window();
        int cyc;
        int ec;
        int dev;
        bit ok;
        bit was;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!meas_valid && cyc < 150);
        chk($sformatf("win%0d_meas_valid_seen", win), 32'(meas_valid), 32'd1);
        if (!meas_valid) return;
        chk($sformatf("win%0d_timing", win), 32'(mon_n), 32'(GATE * (win + 1)));
        ec = exp_count(win);
        chk($sformatf("win%0d_edge_count", win), 32'(edge_count), 32'(ec));
        dev = (ec > EXP) ? ec - EXP : EXP - ec;
        ok  = (dev <= TOL);
        was = m_locked;
        if (!m_locked) begin
            if (ok) begin
                m_run++;
                if (m_run == LCNT) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (!ok) begin
            m_locked = 1'b0;
            m_lost   = 1'b1;
        end
        chk($sformatf("win%0d_locked", win), 32'(locked), 32'(m_locked));
        chk($sformatf("win%0d_lock_lost", win), 32'(lock_lost), 32'(m_lost));
        chk($sformatf("win%0d_rst_out", win), 32'(rst_out), 32'(!(was && m_locked)));
        @(negedge clk);
        chk($sformatf("win%0d_mv_pulse", win), 32'(meas_valid), 32'd0);
        chk($sformatf("win%0d_rst_out_next", win), 32'(rst_out), 32'(!m_locked));
        chk($sformatf("win%0d_locked_next", win), 32'(locked), 32'(m_locked));
        win++;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_rst_out", 32'(rst_out), 32'd1);
        chk("rst_edge_count", 32'(edge_count), 32'd0);
        chk("rst_meas_valid", 32'(meas_valid), 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);
        reset_model();
        rst = 1'b0;

        // Nominal acquisition
        check_window();
        chk("first_win_12_13", 32'(edge_count >= 12 && edge_count <= 13), 32'd1);
        repeat (3) check_window();
        chk("acq_locked", 32'(locked), 32'd1);
        chk("acq_no_lost", 32'(lock_lost), 32'd0);

        // Dead reference while locked, then restart and relock
        ref_on = 1'b0;
        check_window();
        chk("dead_unlocked", 32'(locked), 32'd0);
        chk("dead_lost", 32'(lock_lost), 32'd1);
        check_window();
        chk("dead_zero", 32'(edge_count), 32'd0);
        ref_on = 1'b1;
        repeat (5) check_window();
        chk("relock", 32'(locked), 32'd1);
        chk("relock_lost_sticky", 32'(lock_lost), 32'd1);

        // Off-frequency, then alternating good/bad windows
        ref_period = 6;
        repeat (5) check_window();
        chk("offfreq_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 6; i++) begin
            ref_period = (i % 2 == 0) ? 8 : 6;
            check_window();
            chk($sformatf("alt%0d_unlocked", i), 32'(locked), 32'd0);
        end

        // Randomized reference periods around nominal
        repeat (8) begin
            case ($urandom_range(0, 4))
                0:       ref_period = 7;
                4:       ref_period = 9;
                default: ref_period = 8;
            endcase
            check_window();
        end

        // Single edge landing on the terminal gate cycle
        ref_man_val = 1'b0;
        ref_manual  = 1'b1;
        repeat (2) check_window();
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while ((mon_n % GATE) != 97 && cyc < 200);
        chk("boundary_align", 32'(mon_n % GATE), 32'd97);
        ref_man_val = 1'b1;
        check_window();
        chk("boundary_in_closing", 32'(edge_count), 32'd1);
        check_window();
        chk("boundary_not_next", 32'(edge_count), 32'd0);

        // Async reset mid-window while locked
        ref_manual = 1'b0;
        ref_period = 8;
        repeat (5) check_window();
        chk("pre_reset_locked", 32'(locked), 32'd1);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while ((mon_n % GATE) != 50 && cyc < 200);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_locked", 32'(locked), 32'd0);
        chk("async_rst_rst_out", 32'(rst_out), 32'd1);
        chk("async_rst_lost", 32'(lock_lost), 32'd0);
        chk("async_rst_edge_count", 32'(edge_count), 32'd0);
        reset_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) check_window();
        chk("post_rst_not_early", 32'(locked), 32'd0);
        check_window();
        chk("post_rst_relock", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
